// File: rtl/stopwatch_core.sv
// Four-digit M:SS.t stopwatch with a tick prescaler, up/down counting, preload and lap freeze.
// The digits drive the seven-segment mux directly, one BCD nibble per digit.
module stopwatch_core #(
    parameter int TICK_DIV = 250000,
    parameter int DIV_W    = 18,
    parameter int MIN_MAX  = 9,
    parameter int WRAP     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       mode,
    input  logic       load,
    input  logic [3:0] load_min,
    input  logic [3:0] load_sec10,
    input  logic [3:0] load_sec1,
    input  logic [3:0] load_tenth,
    output logic [3:0] num_1,
    output logic [3:0] num_2,
    output logic [3:0] num_3,
    output logic [3:0] num_4,
    output logic       running,
    output logic       lap_active,
    output logic       done,
    output logic       tick
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0]       MIN_LIM  = 4'(MIN_MAX);
    localparam logic [15:0]      CNT_MAX  = {MIN_LIM, 4'd5, 4'd9, 4'd9};
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

    state_t           state_r, state_s;
    logic [15:0]      cnt_r, cnt_s;
    logic [15:0]      cap_r, cap_s;
    logic [15:0]      num_r;
    logic [DIV_W-1:0] div_r, div_s;
    logic             mode_r, mode_s;
    logic             lap_r, lap_s;
    logic             tick_r, tick_s;
    logic             running_r, done_r;
    logic             term_s;
    logic [15:0]      step_s;

    function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] lim);
        if (d > lim) begin
            return lim;
        end else begin
            return d;
        end
    endfunction

    // Counter is {min, sec10, sec1, tenth}; callers never pass the maximum value.
    function automatic logic [15:0] count_up(input logic [15:0] c);
        logic [3:0] m, s10, s1, t;
        {m, s10, s1, t} = c;
        if (t != 4'd9) begin
            t = t + 4'd1;
        end else begin
            t = 4'd0;
            if (s1 != 4'd9) begin
                s1 = s1 + 4'd1;
            end else begin
                s1 = 4'd0;
                if (s10 != 4'd5) begin
                    s10 = s10 + 4'd1;
                end else begin
                    s10 = 4'd0;
                    m   = (m == MIN_LIM) ? 4'd0 : m + 4'd1;
                end
            end
        end
        return {m, s10, s1, t};
    endfunction

    // Callers never pass zero, so the minutes borrow cannot underflow.
    function automatic logic [15:0] count_down(input logic [15:0] c);
        logic [3:0] m, s10, s1, t;
        {m, s10, s1, t} = c;
        if (t != 4'd0) begin
            t = t - 4'd1;
        end else begin
            t = 4'd9;
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd9;
                if (s10 != 4'd0) begin
                    s10 = s10 - 4'd1;
                end else begin
                    s10 = 4'd5;
                    m   = (m != 4'd0) ? m - 4'd1 : MIN_LIM;
                end
            end
        end
        return {m, s10, s1, t};
    endfunction

    // Next-state logic: load beats start_stop, which beats lap.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        cap_s   = cap_r;
        div_s   = div_r;
        mode_s  = mode_r;
        lap_s   = lap_r;
        tick_s  = 1'b0;
        term_s  = 1'b0;
        step_s  = 16'd0;
        if (load && (state_r != ST_RUN)) begin
            state_s = ST_IDLE;
            cnt_s   = {sat_digit(load_min, MIN_LIM), sat_digit(load_sec10, 4'd5),
                       sat_digit(load_sec1, 4'd9), sat_digit(load_tenth, 4'd9)};
            div_s   = DIV_ZERO;
            lap_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_stop) begin
                        mode_s  = mode;
                        div_s   = DIV_ZERO;
                        lap_s   = 1'b0;
                        state_s = (mode && (cnt_r == 16'd0)) ? ST_DONE : ST_RUN;
                    end else begin
                        lap_s = lap ? 1'b0 : lap_r;
                    end
                end
                ST_RUN: begin
                    if (div_r == DIV_LAST) begin
                        div_s  = DIV_ZERO;
                        tick_s = 1'b1;
                        if (!mode_r) begin
                            if (cnt_r == CNT_MAX) begin
                                cnt_s  = (WRAP != 0) ? 16'd0 : cnt_r;
                                term_s = (WRAP == 0);
                            end else begin
                                cnt_s = count_up(cnt_r);
                            end
                        end else begin
                            if (cnt_r == 16'd0) begin
                                term_s = 1'b1;
                            end else begin
                                step_s = count_down(cnt_r);
                                cnt_s  = step_s;
                                term_s = (step_s == 16'd0);
                            end
                        end
                    end else begin
                        div_s = div_r + DIV_ONE;
                    end
                    // A terminal tick wins over a pause so a finished count never sits in PAUSED.
                    if (term_s) begin
                        state_s = ST_DONE;
                        lap_s   = 1'b0;
                    end else if (start_stop) begin
                        state_s = ST_PAUSED;
                    end else if (lap) begin
                        lap_s = !lap_r;
                        cap_s = lap_r ? cap_r : cnt_s;
                    end else begin
                        lap_s = lap_r;
                    end
                end
                ST_PAUSED: begin
                    if (start_stop) begin
                        state_s = ST_RUN;
                    end else begin
                        lap_s = lap ? 1'b0 : lap_r;
                    end
                end
                ST_DONE: begin
                    if (start_stop) begin
                        state_s = ST_IDLE;
                    end else begin
                        lap_s = lap ? 1'b0 : lap_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, counter and registered outputs; display follows the counter or the lap capture one cycle late.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            cap_r     <= 16'd0;
            num_r     <= 16'd0;
            div_r     <= DIV_ZERO;
            mode_r    <= 1'b0;
            lap_r     <= 1'b0;
            tick_r    <= 1'b0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            cap_r     <= cap_s;
            num_r     <= lap_r ? cap_r : cnt_r;
            div_r     <= div_s;
            mode_r    <= mode_s;
            lap_r     <= lap_s;
            tick_r    <= tick_s;
            running_r <= (state_s == ST_RUN);
            done_r    <= (state_s == ST_DONE);
        end
    end

    assign num_1      = num_r[15:12];
    assign num_2      = num_r[11:8];
    assign num_3      = num_r[7:4];
    assign num_4      = num_r[3:0];
    assign running    = running_r;
    assign lap_active = lap_r;
    assign done       = done_r;
    assign tick       = tick_r;

endmodule
